// File: rtl/instruction_fetch_unit_if.sv
// Instruction memory read bus: registered req/addr from fetch,
// ack/rdata returned by the memory.
interface instruction_fetch_unit_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output mem_req,
      output mem_addr,
      input  mem_ack,
      input  mem_rdata
   );

   modport slave (
      input  mem_req,
      input  mem_addr,
      output mem_ack,
      output mem_rdata
   );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC, req/ack instruction reads, instruction register
// with its PC, stall and redirect handling.
module instruction_fetch_unit #(
   parameter int              ADDR_W   = 16,
   parameter int              DATA_W   = 16,
   parameter int              IMM_W    = 8,
   parameter logic [ADDR_W-1:0] PC_RESET = '0,
   parameter int              PC_STEP  = 2
) (
   input  logic              clk,
   input  logic              reset,
   instruction_fetch_unit_if.master mem,
   input  logic              stall,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic [DATA_W-1:0] instr,
   output logic              instr_valid,
   output logic [ADDR_W-1:0] pc_out,
   output logic [3:0]        opcode,
   output logic [IMM_W-1:0]  imm8_out
);

   typedef enum logic [1:0] {
      REQ,
      WAIT,
      HOLD,
      DRAIN
   } state_t;

   state_t            state, state_n;
   logic [ADDR_W-1:0] pc, pc_n;
   logic              req_n;
   logic [ADDR_W-1:0] addr_n;
   logic [DATA_W-1:0] instr_n;
   logic              valid_n;
   logic [ADDR_W-1:0] pc_out_n;
   logic [ADDR_W-1:0] pc_inc;
   logic              ack;
   logic              slot_free;

   assign pc_inc    = pc + ADDR_W'(PC_STEP);
   assign ack       = mem.mem_req & mem.mem_ack;
   assign slot_free = ~instr_valid | ~stall;
   assign opcode    = instr[DATA_W-1 -: 4];
   assign imm8_out  = instr[IMM_W-1:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= REQ;
         pc           <= PC_RESET;
         mem.mem_req  <= 1'b0;
         mem.mem_addr <= PC_RESET;
         instr        <= '0;
         instr_valid  <= 1'b0;
         pc_out       <= '0;
      end else begin
         state        <= state_n;
         pc           <= pc_n;
         mem.mem_req  <= req_n;
         mem.mem_addr <= addr_n;
         instr        <= instr_n;
         instr_valid  <= valid_n;
         pc_out       <= pc_out_n;
      end
   end

   always_comb begin
      state_n  = state;
      pc_n     = pc;
      req_n    = mem.mem_req;
      addr_n   = mem.mem_addr;
      instr_n  = instr;
      valid_n  = instr_valid & stall;
      pc_out_n = pc_out;
      if (redirect) begin
         pc_n    = redirect_pc;
         valid_n = 1'b0;
         // An unacked request must still complete on the bus.
         if (mem.mem_req && !mem.mem_ack) begin
            state_n = DRAIN;
         end else begin
            state_n = REQ;
            req_n   = 1'b0;
         end
      end else begin
         unique case (state)
            REQ: begin
               req_n   = 1'b1;
               addr_n  = pc;
               state_n = WAIT;
            end
            WAIT: begin
               if (ack) begin
                  if (slot_free) begin
                     instr_n  = mem.mem_rdata;
                     pc_out_n = mem.mem_addr;
                     valid_n  = 1'b1;
                     pc_n     = pc_inc;
                     addr_n   = pc_inc;
                  end else begin
                     // Word dropped; pc unchanged so it is refetched.
                     req_n   = 1'b0;
                     state_n = HOLD;
                  end
               end
            end
            HOLD: begin
               if (!stall) state_n = REQ;
            end
            DRAIN: begin
               if (ack) begin
                  req_n   = 1'b0;
                  state_n = REQ;
               end
            end
            default: state_n = REQ;
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a scoreboard of
// expected (pc, instr) pairs consumed by the decode side.
module tb_instruction_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic [15:0] instr;
   logic        instr_valid;
   logic [15:0] pc_out;
   logic [3:0]  opcode;
   logic [7:0]  imm8_out;

   instruction_fetch_unit_if #(.ADDR_W(16), .DATA_W(16)) bus ();

   instruction_fetch_unit dut (
      .clk         (clk),
      .reset       (reset),
      .mem         (bus.master),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .instr       (instr),
      .instr_valid (instr_valid),
      .pc_out      (pc_out),
      .opcode      (opcode),
      .imm8_out    (imm8_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] a;
      logic [15:0] d;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic logic [15:0] rom(input logic [15:0] a);
      case (a)
         16'h0000: rom = 16'h1083;
         16'h0002: rom = 16'h2003;
         16'h0004: rom = 16'h3055;
         16'h0006: rom = 16'h6A11;
         16'hFFFE: rom = 16'h5C80;
         default:  rom = 16'hE000 ^ a;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [15:0] a);
      exp_t e;
      e.a = a;
      e.d = rom(a);
      sb.push_back(e);
   endtask

   // Drive one cycle of inputs at the negedge; pop on consumption.
   task automatic drv(input logic a, input logic s, input logic r,
                      input logic [15:0] rpc);
      exp_t e;
      bus.mem_ack   = a;
      bus.mem_rdata = a ? rom(bus.mem_addr) : 16'h0000;
      stall         = s;
      redirect      = r;
      redirect_pc   = rpc;
      #1;
      if (instr_valid && !stall && !redirect && !reset) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL sb_underflow: observed pc %h expected none",
                   pc_out);
         end else begin
            e = sb.pop_front();
            chk("sb_pc", 32'(pc_out), 32'(e.a));
            chk("sb_instr", 32'(instr), 32'(e.d));
            chk("sb_opcode", 32'(opcode), 32'(e.d[15:12]));
            chk("sb_imm8", 32'(imm8_out), 32'(e.d[7:0]));
         end
      end
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset         = 1'b1;
      stall         = 1'b0;
      redirect      = 1'b0;
      redirect_pc   = 16'h0000;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 16'h0000;
      repeat (2) @(negedge clk);
      chk("rst_req", 32'(bus.mem_req), 0);
      chk("rst_valid", 32'(instr_valid), 0);
      chk("rst_instr", 32'(instr), 0);
      chk("rst_pc_out", 32'(pc_out), 0);
      reset = 1'b0;
      @(negedge clk);
      chk("first_req", 32'(bus.mem_req), 1);
      chk("first_addr", 32'(bus.mem_addr), 32'h0000);

      push(16'h0000);
      drv(1, 0, 0, 0);
      chk("zw1_valid", 32'(instr_valid), 1);
      chk("zw1_opcode", 32'(opcode), 1);
      chk("zw1_imm", 32'(imm8_out), 32'h83);
      chk("zw1_addr", 32'(bus.mem_addr), 32'h0002);
      push(16'h0002);
      drv(1, 0, 0, 0);
      chk("zw2_valid", 32'(instr_valid), 1);
      chk("zw2_opcode", 32'(opcode), 2);
      chk("zw2_imm", 32'(imm8_out), 32'h03);
      chk("zw2_pc_out", 32'(pc_out), 32'h0002);

      for (int i = 0; i < 3; i++) begin
         drv(0, 0, 0, 0);
         chk("dly_addr", 32'(bus.mem_addr), 32'h0004);
         chk("dly_req", 32'(bus.mem_req), 1);
         chk("dly_valid", 32'(instr_valid), 0);
      end
      push(16'h0004);
      drv(1, 0, 0, 0);
      chk("dly_rise", 32'(instr_valid), 1);
      chk("dly_addr_next", 32'(bus.mem_addr), 32'h0006);

      drv(1, 1, 0, 0);
      chk("stl_req", 32'(bus.mem_req), 0);
      chk("stl_instr", 32'(instr), 32'h3055);
      for (int i = 0; i < 3; i++) begin
         drv(0, 1, 0, 0);
         chk("stl_hold_req", 32'(bus.mem_req), 0);
         chk("stl_hold_instr", 32'(instr), 32'h3055);
         chk("stl_hold_valid", 32'(instr_valid), 1);
      end
      drv(0, 0, 0, 0);
      chk("stl_rel_valid", 32'(instr_valid), 0);
      drv(0, 0, 0, 0);
      chk("stl_resume_req", 32'(bus.mem_req), 1);
      chk("stl_resume_addr", 32'(bus.mem_addr), 32'h0006);

      push(16'h0006);
      drv(1, 0, 0, 0);
      drv(0, 0, 0, 0);
      chk("rd_pend_addr", 32'(bus.mem_addr), 32'h0008);
      drv(0, 0, 1, 16'h0040);
      chk("rd_valid", 32'(instr_valid), 0);
      chk("rd_drain_req", 32'(bus.mem_req), 1);
      chk("rd_drain_addr", 32'(bus.mem_addr), 32'h0008);
      drv(0, 0, 0, 0);
      chk("rd_drain_hold", 32'(bus.mem_addr), 32'h0008);
      drv(1, 0, 0, 0);
      chk("rd_drop_valid", 32'(instr_valid), 0);
      chk("rd_drop_req", 32'(bus.mem_req), 0);
      drv(0, 0, 0, 0);
      chk("rd_new_addr", 32'(bus.mem_addr), 32'h0040);
      chk("rd_new_req", 32'(bus.mem_req), 1);

      drv(1, 0, 1, 16'hFFFE);
      chk("wr_req", 32'(bus.mem_req), 0);
      chk("wr_valid", 32'(instr_valid), 0);
      drv(0, 0, 0, 0);
      chk("wr_addr", 32'(bus.mem_addr), 32'hFFFE);
      push(16'hFFFE);
      drv(1, 0, 0, 0);
      chk("wr_pc_out1", 32'(pc_out), 32'hFFFE);
      chk("wr_addr_wrap", 32'(bus.mem_addr), 32'h0000);
      push(16'h0000);
      drv(1, 0, 0, 0);
      chk("wr_pc_out2", 32'(pc_out), 32'h0000);
      drv(0, 0, 0, 0);

      reset = 1'b1;
      drv(0, 0, 0, 0);
      chk("mid_rst_req", 32'(bus.mem_req), 0);
      chk("mid_rst_valid", 32'(instr_valid), 0);
      reset = 1'b0;
      drv(1, 0, 0, 0);
      chk("stray_valid", 32'(instr_valid), 0);
      chk("stray_instr", 32'(instr), 0);
      chk("stray_addr", 32'(bus.mem_addr), 32'h0000);
      drv(0, 0, 0, 0);
      chk("sb_leftover", 32'(sb.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
